// File: rtl/istr_decode_queue.sv
// istr_decode_queue: decoding instruction FIFO between fetch and ID.
// Splits each 32-bit MIPS word into fields when it is written, then buffers
// DEPTH decoded entries behind a valid/ready handshake on both sides.
// Optional feature macro: ISTR_SPLIT_SYSCALL_REMAP_EN (SYSCALL RS/RT remap).
module istr_decode_queue #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 2,
  parameter logic [4:0]  SYS_RS = 5'd2,
  parameter logic [4:0]  SYS_RT = 5'd4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_istr,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [5:0]                   out_op,
  output logic [5:0]                   out_func,
  output logic [4:0]                   out_rs,
  output logic [4:0]                   out_rt,
  output logic [4:0]                   out_rd,
  output logic [4:0]                   out_shamt,
  output logic [15:0]                  out_imm16,
  output logic [25:0]                  out_imm26,
  output logic                         out_syscall,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  // A 1-entry queue still needs a 1-bit pointer; it simply never leaves 0.
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      func;
    logic [15:0]     imm16;
    logic [25:0]     imm26;
    logic            syscall;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Handshake status depends on registered occupancy only.
  assign in_ready  = (count_q < CntFull);
  assign out_valid = (count_q != '0);
  assign out_count = count_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Field split of the incoming word, with optional SYSCALL operand remap.
  always_comb begin
    wr_entry         = '0;
    wr_entry.op      = in_istr[31:26];
    wr_entry.rs      = in_istr[25:21];
    wr_entry.rt      = in_istr[20:16];
    wr_entry.rd      = in_istr[15:11];
    wr_entry.shamt   = in_istr[10:6];
    wr_entry.func    = in_istr[5:0];
    wr_entry.imm16   = in_istr[15:0];
    wr_entry.imm26   = in_istr[25:0];
    wr_entry.syscall = (in_istr[31:26] == 6'h00) && (in_istr[5:0] == 6'h0C);
    wr_entry.pc      = in_pc;
`ifdef ISTR_SPLIT_SYSCALL_REMAP_EN
    if (wr_entry.syscall) begin
      wr_entry.rs = SYS_RS;
      wr_entry.rt = SYS_RT;
    end
`endif
  end

  // Next-state for pointers and occupancy; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is left unreset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head entry, forced to zero when the queue is empty.
  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign out_op      = head.op;
  assign out_rs      = head.rs;
  assign out_rt      = head.rt;
  assign out_rd      = head.rd;
  assign out_shamt   = head.shamt;
  assign out_func    = head.func;
  assign out_imm16   = head.imm16;
  assign out_imm26   = head.imm26;
  assign out_syscall = head.syscall;
  assign out_pc      = head.pc;

endmodule

// File: tb/tb_istr_decode_queue.sv
// Scoreboard bench for istr_decode_queue (DEPTH=2, PC_W=32).
module tb_istr_decode_queue;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_istr, in_pc, out_pc;
  logic [5:0]  out_op, out_func;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm16;
  logic [25:0] out_imm26;
  logic        out_syscall;
  logic [1:0]  out_count;

  istr_decode_queue #(.PC_W(32), .DEPTH(2), .SYS_RS(5'd2), .SYS_RT(5'd4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_istr(in_istr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_func(out_func), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt), .out_imm16(out_imm16),
    .out_imm26(out_imm26), .out_syscall(out_syscall), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-decoded vectors: fields = {op,rs,rt,rd,shamt,func,imm16,syscall}, wide = {imm26,pc}.
  logic [31:0] v_istr   [6];
  logic [48:0] v_fields [6];
  logic [57:0] v_wide   [6];
  int          sb [$];
  int          mon_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int idx);
    int n = 0;
    in_valid = 1'b1;
    in_istr  = v_istr[idx];
    in_pc    = v_wide[idx][31:0];
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    else sb.push_back(idx);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic any_field();
    return |{out_op, out_rs, out_rt, out_rd, out_shamt, out_func, out_imm16, out_imm26,
             out_syscall, out_pc};
  endfunction

  // Monitor: compares the head against the scoreboard on every pop handshake.
  always @(negedge clk) begin
    #4;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 64'(sb.size()), 64'd1);
      end else begin
        mon_idx = sb.pop_front();
        chk("pop_fields", 64'({out_op, out_rs, out_rt, out_rd, out_shamt, out_func, out_imm16,
                                out_syscall}), 64'(v_fields[mon_idx]));
        chk("pop_imm26_pc", 64'({out_imm26, out_pc}), 64'(v_wide[mon_idx]));
      end
    end
  end

  initial begin
    v_istr[0] = 32'h012A4020;
    v_fields[0] = {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 1'b0};
    v_wide[0] = {26'h12A4020, 32'h00400000};
    v_istr[1] = 32'h0000000C;
`ifdef ISTR_SPLIT_SYSCALL_REMAP_EN
    v_fields[1] = {6'h00, 5'd2, 5'd4, 5'd0, 5'd0, 6'h0C, 16'h000C, 1'b1};
`else
    v_fields[1] = {6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0C, 16'h000C, 1'b1};
`endif
    v_wide[1] = {26'h000000C, 32'h00400004};
    v_istr[2] = 32'h8D090004;
    v_fields[2] = {6'h23, 5'd8, 5'd9, 5'd0, 5'd0, 6'h04, 16'h0004, 1'b0};
    v_wide[2] = {26'h1090004, 32'h00400008};
    v_istr[3] = 32'h00094080;
    v_fields[3] = {6'h00, 5'd0, 5'd9, 5'd8, 5'd2, 6'h00, 16'h4080, 1'b0};
    v_wide[3] = {26'h0094080, 32'h0040000C};
    v_istr[4] = 32'h0000000D;
    v_fields[4] = {6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0D, 16'h000D, 1'b0};
    v_wide[4] = {26'h000000D, 32'h00400010};
    v_istr[5] = 32'h0400000C;
    v_fields[5] = {6'h01, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0C, 16'h000C, 1'b0};
    v_wide[5] = {26'h000000C, 32'h00400014};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_istr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_count", 64'(out_count), 64'd0);
    chk("reset_fields_zero", 64'(any_field()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single push: one-cycle latency, then a run of distinct encodings.
    out_ready = 1'b1;
    send(0);
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_count", 64'(out_count), 64'd1);
    for (int i = 1; i < 6; i++) send(i);
    repeat (2) @(negedge clk);
    chk("drain_count", 64'(out_count), 64'd0);
    chk("empty_fields_zero", 64'(any_field()), 64'd0);

    // Backpressure: third word held until the first pop frees a slot.
    out_ready = 1'b0;
    send(0);
    send(2);
    in_valid = 1'b1; in_istr = v_istr[3]; in_pc = v_wide[3][31:0];
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(out_count), 64'd2);
    out_ready = 1'b1;
    send(3);
    repeat (3) @(negedge clk);
    chk("bp_drain_count", 64'(out_count), 64'd0);

    // Streaming push/pop with occupancy pinned at one across pointer wraps.
    for (int k = 0; k < 16; k++) begin
      send(k % 6);
      chk("stream_count", 64'(out_count), 64'd1);
    end
    repeat (2) @(negedge clk);
    chk("stream_drain_count", 64'(out_count), 64'd0);

    // Flush a full queue while fetch offers another word.
    out_ready = 1'b0;
    send(0);
    send(1);
    flush = 1'b1; in_valid = 1'b1; in_istr = v_istr[2]; in_pc = v_wide[2][31:0];
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_count", 64'(out_count), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(4);
    repeat (2) @(negedge clk);

    // Asynchronous reset between edges with two entries buffered.
    out_ready = 1'b0;
    send(0);
    send(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_count", 64'(out_count), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_fields_zero", 64'(any_field()), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    send(5);
    chk("post_reset_count", 64'(out_count), 64'd1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/istr_decode_queue.md
# istr_decode_queue

Parametrised successor to the combinational instruction splitter. It accepts fetched 32-bit MIPS instructions with their PC over a valid/ready handshake, splits each into OP/RS/RT/RD/SHAMT/FUNC/IMM16/IMM26 fields at write time, and buffers the decoded entries in a DEPTH-entry FIFO. It sits between fetch and the register-file/ID stage, decoupling fetch stalls from decode. It supports pipeline flush and, optionally, SYSCALL operand remapping.

## Interface
- PC_W, 32, width of the PC carried with each instruction
- DEPTH, 2, FIFO entries; power of two, 1..16
- SYS_RS, 5'd2, RS index substituted on SYSCALL ($v0)
- SYS_RT, 5'd4, RT index substituted on SYSCALL ($a0)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue accepts; high iff count < DEPTH
- in_istr  in  32  raw instruction word
- in_pc  in  PC_W  PC of in_istr
- out_valid  out  1  head entry present (count != 0)
- out_ready  in  1  consumer takes head entry
- out_pc  out  PC_W  head PC
- out_op, out_func  out  6  Istr[31:26], Istr[5:0]
- out_rs, out_rt, out_rd, out_shamt  out  5  Istr[25:21], [20:16], [15:11], [10:6] (RS/RT subject to remap)
- out_imm16  out  16  Istr[15:0]
- out_imm26  out  26  Istr[25:0]
- out_syscall  out  1  head is SYSCALL (OP=0, FUNC=6'h0C)
- out_count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Push: in_valid & in_ready at a rising edge writes decoded fields, syscall flag and PC into entry wr_ptr; wr_ptr increments mod DEPTH.
- Pop: out_valid & out_ready at a rising edge advances rd_ptr mod DEPTH.
- Push and pop in the same cycle: both occur, count unchanged. When full, in_ready=0 even if out_ready=1 (no pass-through); no combinational path from out_ready to in_ready.
- Empty: out_valid=0; all out_* field outputs and out_syscall driven 0; out_ready ignored.
- flush=1: count, wr_ptr, rd_ptr cleared at the edge; a same-cycle push or pop is discarded. Flush has priority over push/pop.
- Decode is a pure bit-slice except SYSCALL remap (see Configuration). Entry storage need not be reset; outputs are masked by out_valid.

## Timing
- Reset (rst_n=0, asynchronous): count=0, pointers=0, out_valid=0, in_ready=1, all field outputs 0, out_count=0.
- Latency: instruction pushed at edge N is visible on out_* with out_valid=1 after edge N (1 cycle), if queue was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- in_ready, out_valid, out_count are functions of registered state only.
- Reset release mid-operation: all buffered entries lost; first push after release behaves as from empty.
- DEPTH=1: queue alternates full/empty; max throughput 1 entry per 2 cycles.

## Configuration
- ISTR_SPLIT_SYSCALL_REMAP_EN defined: on SYSCALL, out_rs=SYS_RS, out_rt=SYS_RT; all other fields are the raw slices.
- Not defined: out_rs/out_rt are always raw Istr[25:21]/[20:16]; out_syscall is still generated.

## Test plan
- Reset then push 32'h012A4020 (add $t0,$t1,$t2) at PC 0x00400000 -> next cycle out_valid=1, op=0, rs=9, rt=10, rd=8, shamt=0, func=6'h20, out_pc=0x00400000.
- Push SYSCALL 32'h0000000C with REMAP_EN -> rs=2, rt=4, out_syscall=1; without macro -> rs=0, rt=0, out_syscall=1.
- DEPTH=2, out_ready=0, push 3 instructions -> third held (in_ready=0 after two), out_count=2; raise out_ready -> order preserved, third accepted after first pop.
- Continuous push/pop with count=1 for 16 cycles incl. pointer wrap -> one output per cycle, count stays 1, no loss/duplication.
- Full queue, assert flush with simultaneous in_valid -> next cycle out_valid=0, count=0, in_ready=1, flushed-cycle instruction not stored.
- Assert rst_n=0 mid-cycle with 2 entries -> outputs zero immediately (asynchronous), before next clock edge.
